nibble_deser_4b_5to1: RTL and testbench
=======================================

# nibble_deser_4b_5to1

Collects a stream of 4-bit nibbles arriving on a val/rdy input interface and steers each one into the next of five lane registers in rotating order (lane 0 through lane 4). Once all five lanes are filled, it presents them as one frame on a val/rdy output interface. It is the sequential counterpart of the 1-to-5 nibble demux and sits on the consuming side of the narrow 4-bit datapath, reassembling 20-bit frames for downstream blocks.

## Interface

Parameters:
- None. Lane width is fixed at 4 bits and lane count is fixed at 5.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in_val  input  1  input nibble valid
- in_rdy  output  1  block can accept a nibble this cycle
- in_  input  4  input nibble
- out_val  output  1  complete five-lane frame available
- out_rdy  input  1  downstream accepts the frame this cycle
- out0 .. out4  output  4 each  lane registers 0..4 (lane N holds the Nth nibble of the frame)
- sel  output  3  index of the lane the next accepted nibble will be written to (0..4)

## Operation

- State machine with two states:
  - FILL: accumulating nibbles.
  - FULL: frame held for output.
- Input transfer occurs when in_val && in_rdy. Output transfer occurs when out_val && out_rdy.
- in_rdy = (state == FILL) || out_rdy. This is combinational from state and out_rdy, with no path from in_val.
- out_val = (state == FULL).
- FILL behaviour, on each input transfer:
  - The lane addressed by sel is loaded with in_.
  - If sel == 4: sel becomes 0 and the state goes to FULL.
  - Otherwise: sel increments by 1.
- FULL behaviour:
  - Lane registers hold; sel holds at 0.
  - On an output transfer with no input transfer: the state goes to FILL.
  - On an output transfer and an input transfer in the same cycle: lane 0 is loaded with in_, sel becomes 1, and the state goes to FILL. The old frame is consumed and the new frame starts with no bubble.
- Lanes that have not yet been written in the current frame keep their stale values. out0..out4 are only meaningful while out_val = 1.
- sel never takes the values 5..7. No modular arithmetic beyond the explicit wrap from 4 to 0.
- Reset values: state = FILL, sel = 0, out0..out4 = 0, out_val = 0. in_rdy is therefore 1 after reset.
- Reset mid-frame: the partial frame is discarded and all state returns to its reset values on the next edge. Reset takes priority over any simultaneous transfer.

## Timing

- Latency: out_val rises on the edge that accepts the 5th nibble, so it is visible in the cycle after the 5th transfer.
- Throughput: with in_val held at 1 and out_rdy held at 1, the block sustains one nibble per cycle and one frame per 5 cycles, with no idle cycles between frames.
- Backpressure: while FULL with out_rdy = 0, in_rdy = 0 and nothing is accepted. Lanes and out_val stay stable until out_rdy = 1.
- in_val may toggle freely. A cycle with in_val = 0 leaves sel and the lanes unchanged.
- in_ is sampled only on an input transfer. Values present when in_rdy = 0 or in_val = 0 are ignored.

## Test plan

- Reset then basic fill: feed 5 nibbles 0x1, 0x2, 0x3, 0x4, 0x5 back-to-back with out_rdy = 1. Required: sel steps 0,1,2,3,4; out_val = 1 in the following cycle with out0..out4 = 1,2,3,4,5; out_val falls the cycle after.
- Backpressure: fill a frame with 0xA..0xE and hold out_rdy = 0 for 3 cycles while in_val = 1 with in_ = 0xF. Required: in_rdy = 0 and lanes hold 0xA..0xE for all 3 cycles. When out_rdy goes to 1: frame accepted, lane 0 = 0xF, sel = 1.
- Back-to-back streaming: 15 consecutive nibbles 0..14 with in_val = 1 and out_rdy = 1. Required: three frames (0..4, 5..9, 10..14), with out_val asserted in cycles 5, 10 and 15 after the first transfer and no dropped nibble.
- Gapped input: nibbles 0x7, 0x8, 0x9, 0x6, 0x5 with in_val = 0 cycles interleaved. Required: sel advances only on transfers; frame reads 7,8,9,6,5.
- Reset mid-frame: accept 3 nibbles, assert reset for 1 cycle, then send 5 nibbles 0xC. Required: immediately after reset, sel = 0, out_val = 0 and out0..out4 = 0; the next frame is all 0xC, with no stale nibbles from the partial frame.

Source files
------------

// File: rtl/nibble_deser_4b_5to1.sv
// Nibble deserializer: steers val/rdy nibbles into five rotating lane registers
// and presents the completed 20-bit frame on a val/rdy output.
module nibble_deser_4b_5to1 (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_val,
    output logic       in_rdy,
    input  logic [3:0] in_,
    output logic       out_val,
    input  logic       out_rdy,
    output logic [3:0] out0,
    output logic [3:0] out1,
    output logic [3:0] out2,
    output logic [3:0] out3,
    output logic [3:0] out4,
    output logic [2:0] sel
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] sel_next;
    logic       load;
    logic       in_xfer;
    logic       out_xfer;
    logic [3:0] lane [5];

    assign in_rdy   = (state == FILL) || out_rdy;
    assign out_val  = (state == FULL);
    assign in_xfer  = in_val && in_rdy;
    assign out_xfer = out_val && out_rdy;

    // A FULL-state input transfer always lands in lane 0, because sel rests at 0 while FULL
    always_comb begin
        state_next = state;
        sel_next   = sel;
        load       = 1'b0;
        case (state)
            FILL: begin
                if (in_xfer) begin
                    load = 1'b1;
                    if (sel == 3'd4) begin
                        sel_next   = 3'd0;
                        state_next = FULL;
                    end else begin
                        sel_next = sel + 3'd1;
                    end
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_next = FILL;
                    if (in_xfer) begin
                        load     = 1'b1;
                        sel_next = 3'd1;
                    end
                end
            end
            default: begin
                state_next = FILL;
                sel_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
            sel   <= 3'd0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) begin
                lane[i] <= 4'h0;
            end
        end else if (load) begin
            for (int i = 0; i < 5; i++) begin
                if (sel == 3'(i)) begin
                    lane[i] <= in_;
                end
            end
        end
    end

    assign out0 = lane[0];
    assign out1 = lane[1];
    assign out2 = lane[2];
    assign out3 = lane[3];
    assign out4 = lane[4];

endmodule

// File: tb/tb_nibble_deser_4b_5to1.sv
// Self-checking bench for nibble_deser_4b_5to1: a reference model tracks the
// handshake and queues expected frames, which are compared when the DUT presents them.
module tb_nibble_deser_4b_5to1;

    logic       clk;
    logic       reset;
    logic       in_val;
    logic       in_rdy;
    logic [3:0] in_;
    logic       out_val;
    logic       out_rdy;
    logic [3:0] out0, out1, out2, out3, out4;
    logic [2:0] sel;

    int checks = 0;
    int errors = 0;

    logic [19:0] exp_q [$];
    logic [3:0]  part [$];
    logic        mdl_full = 1'b0;
    logic        chk_zero = 1'b0;
    logic        exp_rdy;
    logic [3:0]  obs [5];

    nibble_deser_4b_5to1 dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_     (in_),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out0    (out0),
        .out1    (out1),
        .out2    (out2),
        .out3    (out3),
        .out4    (out4),
        .sel     (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [19:0] got, input logic [19:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic v, input logic [3:0] d, input logic r);
        reset   = rst;
        in_val  = v;
        in_     = d;
        out_rdy = r;
        @(posedge clk);
        #1;
    endtask

    // Model evaluated mid-cycle: check what the DUT shows now, then predict the next edge
    always @(negedge clk) begin
        obs = '{out0, out1, out2, out3, out4};
        exp_rdy = !mdl_full || out_rdy;
        if (chk_zero) begin
            for (int i = 0; i < 5; i++) checkOutput("reset_lane", 20'(obs[i]), 20'h0);
        end
        checkOutput("in_rdy", 20'(in_rdy), 20'(exp_rdy));
        checkOutput("out_val", 20'(out_val), 20'(mdl_full));
        checkOutput("sel", 20'(sel), mdl_full ? 20'h0 : 20'(part.size()));
        if (mdl_full) begin
            if (exp_q.size() == 0) begin
                checkOutput("frame_queue", 20'h1, 20'h0);
            end else begin
                checkOutput("frame", {out0, out1, out2, out3, out4}, exp_q[0]);
            end
        end else begin
            for (int i = 0; i < part.size(); i++) checkOutput("lane", 20'(obs[i]), 20'(part[i]));
        end

        if (reset) begin
            mdl_full = 1'b0;
            part.delete();
            exp_q.delete();
            chk_zero = 1'b1;
        end else begin
            chk_zero = 1'b0;
            if (mdl_full && out_rdy) begin
                mdl_full = 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (in_val && exp_rdy) begin
                part.push_back(in_);
                if (part.size() == 5) begin
                    exp_q.push_back({part[0], part[1], part[2], part[3], part[4]});
                    part.delete();
                    mdl_full = 1'b1;
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        in_val  = 1'b0;
        in_     = 4'h0;
        out_rdy = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);

        // Basic fill
        for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b1, 4'(i), 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);

        // Backpressure, then simultaneous consume/accept
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 4'hA + 4'(i), 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 4'hF, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'hF, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h3, 1'b1);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, 4'(i), 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);

        // Back-to-back streaming
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, 4'(i), 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);

        // Gapped input with garbage on idle cycles
        applyStimulus(1'b0, 1'b1, 4'h7, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h1, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'h8, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h2, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h2, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'h9, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'h6, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h4, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'h5, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);

        // Reset mid-frame, with a competing transfer on the reset cycle
        for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 1'b1, 4'(i), 1'b1);
        applyStimulus(1'b1, 1'b1, 4'h9, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 4'hC, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
